// File: rtl/demux_1x8_tdm_pkg.sv
// Shared constants and types for the 1:8 TDM receive demultiplexer.
package demux_pkg;

  localparam int NCH    = 8;
  localparam int FCNT_W = 8;

  typedef logic [2:0] chan_t;

  localparam chan_t LAST_CH = chan_t'(NCH - 1);

endpackage

// File: rtl/demux_1x8_tdm_if.sv
// Data/status bundle of demux_1x8_tdm; sync_in/sync_err exist only with TDM_SYNC_EN.
interface demux_1x8_tdm_if #(
  parameter int WIDTH = 4
);
  import demux_pkg::*;

  logic [WIDTH-1:0]  din;
  logic              din_vld;
  logic [WIDTH-1:0]  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
  logic              frame_vld;
  chan_t             ch;
  logic [FCNT_W-1:0] frame_cnt;
`ifdef TDM_SYNC_EN
  logic              sync_in;
  logic              sync_err;
`endif

  modport master (
    output din, din_vld,
`ifdef TDM_SYNC_EN
    output sync_in,
    input  sync_err,
`endif
    input  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, frame_vld, ch, frame_cnt
  );

  modport slave (
    input  din, din_vld,
`ifdef TDM_SYNC_EN
    input  sync_in,
    output sync_err,
`endif
    output Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, frame_vld, ch, frame_cnt
  );

endinterface

// File: rtl/demux_1x8_tdm_chan_cnt.sv
// Channel index counter: advances per accepted word, wraps 7->0, realigns on sync
// (sync input present only with TDM_SYNC_EN).
module tdm_chan_cnt
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_adv,
`ifdef TDM_SYNC_EN
  input  logic  i_sync,
  output logic  o_realign,
`endif
  output chan_t o_ch,
  output logic  o_wrap
);

  chan_t r_ch;
  logic  w_sync;

`ifdef TDM_SYNC_EN
  assign w_sync    = i_sync;
  // A sync word landing anywhere but channel 0 means the frame in flight is misaligned.
  assign o_realign = i_adv && i_sync && (r_ch != '0);
`else
  assign w_sync    = 1'b0;
`endif

  assign o_wrap = i_adv && !w_sync && (r_ch == LAST_CH);
  assign o_ch   = r_ch;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch <= '0;
    end else if (i_adv) begin
      if (w_sync) r_ch <= chan_t'(1);
      else        r_ch <= r_ch + 1'b1;
    end
  end

endmodule

// File: rtl/demux_1x8_tdm.sv
// 1:8 TDM receive demultiplexer: collects 8 sequential words into shadow registers
// and publishes them as one frame. Optional channel resync with TDM_SYNC_EN.
module demux_1x8_tdm #(
  parameter int WIDTH = 4,
  parameter int NCH   = demux_pkg::NCH
) (
  input  logic           clk,
  input  logic           rst,
  demux_1x8_tdm_if.slave bus
);
  import demux_pkg::*;

  logic [WIDTH-1:0]  r_shadow [NCH];
  logic [WIDTH-1:0]  r_y      [NCH];
  logic              r_frame_vld;
  logic [FCNT_W-1:0] r_frame_cnt;
  chan_t             w_ch;
  chan_t             w_wr_ch;
  logic              w_wrap;

`ifdef TDM_SYNC_EN
  logic r_sync_err;
  logic w_realign;

  tdm_chan_cnt u_chan_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_adv     (bus.din_vld),
    .i_sync    (bus.sync_in),
    .o_realign (w_realign),
    .o_ch      (w_ch),
    .o_wrap    (w_wrap)
  );

  // A sync word always lands in channel 0, whatever the counter says.
  assign w_wr_ch = bus.sync_in ? '0 : w_ch;

  always_ff @(posedge clk) begin
    if (rst) r_sync_err <= 1'b0;
    else     r_sync_err <= w_realign;
  end

  assign bus.sync_err = r_sync_err;
`else
  tdm_chan_cnt u_chan_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_adv  (bus.din_vld),
    .o_ch   (w_ch),
    .o_wrap (w_wrap)
  );

  assign w_wr_ch = w_ch;
`endif

  // NOTE: the shadow and output arrays are reset explicitly because reset must
  // clear them to zero; this keeps them as flops rather than RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        r_shadow[k] <= '0;
        r_y[k]      <= '0;
      end
      r_frame_vld <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_frame_vld <= w_wrap;
      if (bus.din_vld) r_shadow[w_wr_ch] <= bus.din;
      // The last word bypasses its shadow slot so the frame is out one edge later.
      if (w_wrap) begin
        for (int k = 0; k < NCH - 1; k++) r_y[k] <= r_shadow[k];
        r_y[NCH-1]  <= bus.din;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign bus.Y0        = r_y[0];
  assign bus.Y1        = r_y[1];
  assign bus.Y2        = r_y[2];
  assign bus.Y3        = r_y[3];
  assign bus.Y4        = r_y[4];
  assign bus.Y5        = r_y[5];
  assign bus.Y6        = r_y[6];
  assign bus.Y7        = r_y[7];
  assign bus.frame_vld = r_frame_vld;
  assign bus.ch        = w_ch;
  assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_demux_1x8_tdm.sv
// Self-checking bench for demux_1x8_tdm: queue-based frame model checked every cycle,
// plus directed literal checks. Sync scenario runs when TDM_SYNC_EN is defined.
module tb_demux_1x8_tdm;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux_1x8_tdm_if #(.WIDTH(4)) bus ();

  demux_1x8_tdm #(.WIDTH(4), .NCH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] y_of(input int k);
    case (k)
      0: return bus.Y0;
      1: return bus.Y1;
      2: return bus.Y2;
      3: return bus.Y3;
      4: return bus.Y4;
      5: return bus.Y5;
      6: return bus.Y6;
      default: return bus.Y7;
    endcase
  endfunction

  // Model: a frame is simply the list of accepted words; 8 of them publish.
  logic [3:0] part[$];
  logic [3:0] exp_y [8];
  logic [3:0] prev_y[8];
  bit         exp_fv, exp_err, model_ok, last_rst;
  int         exp_cnt;

  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 8; k++) check($sformatf("Y%0d", k), 32'(y_of(k)), 32'(exp_y[k]));
      check("frame_vld", 32'(bus.frame_vld), 32'(exp_fv));
      check("ch", 32'(bus.ch), 32'(part.size()));
      check("frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
`ifdef TDM_SYNC_EN
      check("sync_err", 32'(bus.sync_err), 32'(exp_err));
`endif
      if (bus.frame_vld === 1'b0 && !last_rst)
        for (int k = 0; k < 8; k++) check($sformatf("Y%0d_stable", k), 32'(y_of(k)), 32'(prev_y[k]));
      if (bus.frame_vld === 1'b1) pulses++;
    end
    for (int k = 0; k < 8; k++) prev_y[k] = y_of(k);
    // Advance the model with the inputs the next rising edge will sample.
    last_rst = rst;
    exp_fv   = 1'b0;
    exp_err  = 1'b0;
    if (rst) begin
      part.delete();
      for (int k = 0; k < 8; k++) exp_y[k] = '0;
      exp_cnt = 0;
    end else if (bus.din_vld) begin
`ifdef TDM_SYNC_EN
      if (bus.sync_in) begin
        if (part.size() != 0) exp_err = 1'b1;
        part.delete();
      end
`endif
      part.push_back(bus.din);
      if (part.size() == 8) begin
        for (int k = 0; k < 8; k++) exp_y[k] = part[k];
        exp_fv  = 1'b1;
        exp_cnt = (exp_cnt + 1) % 256;
        part.delete();
      end
    end
    model_ok = 1'b1;
  end

  task automatic send(input logic [3:0] d, input bit s = 1'b0);
    @(posedge clk); #1;
    bus.din     = d;
    bus.din_vld = 1'b1;
`ifdef TDM_SYNC_EN
    bus.sync_in = s;
`else
    if (s) $display("sync requested without sync support");
`endif
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.din_vld = 1'b0;
`ifdef TDM_SYNC_EN
    bus.sync_in = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.din_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 8; k++) check($sformatf("%s_Y%0d", tag, k), 32'(y_of(k)), 32'h0);
    check({tag, "_ch"}, 32'(bus.ch), 32'h0);
    check({tag, "_cnt"}, 32'(bus.frame_cnt), 32'h0);
    check({tag, "_fv"}, 32'(bus.frame_vld), 32'h0);
  endtask

  task automatic check_frame(input string tag, input logic [3:0] w[8], input int cnt);
    for (int k = 0; k < 8; k++) check($sformatf("%s_Y%0d", tag, k), 32'(y_of(k)), 32'(w[k]));
    check({tag, "_fv"}, 32'(bus.frame_vld), 32'h1);
    check({tag, "_cnt"}, 32'(bus.frame_cnt), 32'(cnt));
  endtask

  logic [3:0] w30[8] = '{4'b0101, 4'b1010, 4'b1100, 4'b1101, 4'b0011, 4'b1101, 4'b1100, 4'b1101};
  logic [3:0] w32[8] = '{4'b1100, 4'b1101, 4'b1101, 4'b1111, 4'b1100, 4'b0000, 4'b0011, 4'b1100};

  initial begin
    bus.din     = '0;
    bus.din_vld = 1'b0;
`ifdef TDM_SYNC_EN
    bus.sync_in = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("rst0");

    // Back-to-back frame.
    for (int i = 0; i < 8; i++) send(w30[i]);
    idle();
    check_frame("frame1", w30, 1);
    idle();
    check("frame1_fv_drop", 32'(bus.frame_vld), 32'h0);

    // Same words separated by 1..3 idle cycles.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      send(w30[i]);
      if (i < 7) repeat (i % 3 + 1) idle();
    end
    check("gaps_no_early_pulse", 32'(pulses), 32'h0);
    idle();
    check_frame("gaps", w30, 2);
    repeat (3) idle();
    check("gaps_one_pulse", 32'(pulses), 32'h1);

    // Reset after 3 accepted words discards the partial frame.
    for (int i = 0; i < 3; i++) send(w32[7 - i]);
    do_reset();
    check_reset_state("midrst");
    for (int i = 0; i < 8; i++) send(w32[i]);
    idle();
    check_frame("after_rst", w32, 1);

    // 2056 continuous words: 257 frames, counter wraps to 1.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 2056; i++) send(4'($urandom_range(0, 15)));
    idle();
    repeat (2) idle();
    check("cont_pulses", 32'(pulses), 32'd257);
    check("cont_cnt_wrap", 32'(bus.frame_cnt), 32'd1);

`ifdef TDM_SYNC_EN
    do_reset();
    for (int i = 0; i < 8; i++) send(w30[i]);
    idle();
    check_frame("sync_pre", w30, 1);
    for (int i = 0; i < 5; i++) send(w32[i]);
    send(4'b0111, 1'b1);
    idle();
    check("sync_err_pulse", 32'(bus.sync_err), 32'h1);
    check("sync_ch", 32'(bus.ch), 32'h1);
    check("sync_no_fv", 32'(bus.frame_vld), 32'h0);
    for (int k = 0; k < 8; k++) check($sformatf("sync_hold_Y%0d", k), 32'(y_of(k)), 32'(w30[k]));
    for (int i = 1; i < 8; i++) send(w32[i]);
    idle();
    check("sync_err_clear", 32'(bus.sync_err), 32'h0);
    check("sync_Y0", 32'(bus.Y0), 32'h7);
    check("sync_Y7", 32'(bus.Y7), 32'(w32[7]));
    check("sync_fv", 32'(bus.frame_vld), 32'h1);
    check("sync_cnt", 32'(bus.frame_cnt), 32'h2);
`endif

    repeat (2) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x8_tdm.md
DEMUX_1X8_TDM -- requirements
Module: demux_1x8_tdm

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data width of din and of every output word.
REQ-002 Parameter NCH, default 8, SHALL set the number of output channels; only the value 8 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 din  input  WIDTH  SHALL carry the time-multiplexed data word.
REQ-006 din_vld  input  1  SHALL qualify din; a word is accepted on each rising edge where din_vld=1.
REQ-007 Y0..Y7  output  WIDTH each  SHALL carry the last complete frame, channel k on Yk.
REQ-008 frame_vld  output  1  SHALL pulse high for one cycle when Y0..Y7 update.
REQ-009 ch  output  3  SHALL show the channel index the next accepted word will be written to.
REQ-010 frame_cnt  output  8  SHALL count completed frames.
REQ-011 sync_in  input  1  and  sync_err  output  1  SHALL exist only when TDM_SYNC_EN is defined.

Function
REQ-012 The block SHALL be the receive-side inverse of the team's 8:1 selector: it SHALL steer sequential din words into channels 0,1,...,7 in order.
REQ-013 Each accepted word SHALL be written to shadow register ch, and ch SHALL then increment.
REQ-014 ch SHALL wrap from 7 to 0.
REQ-015 ch SHALL hold when din_vld=0; idle cycles between words SHALL NOT affect frame contents.
REQ-016 On the edge accepting the word for channel 7, all outputs SHALL load together as Y0..Y6 <= shadow0..6 and Y7 <= din.
REQ-017 On that same edge, frame_vld SHALL be set to 1 for exactly one cycle, so the latency from the channel-7 word to the frame output is 1 cycle.
REQ-018 Y0..Y7 SHALL hold their values between frame completions; a partial frame SHALL never be visible on the outputs.
REQ-019 frame_cnt SHALL increment on each frame completion and wrap from 255 to 0.
REQ-020 Back-to-back frames with din_vld held at 1 SHALL be supported with no dead cycle; frame_vld then pulses every 8 cycles.

Reset
REQ-021 While rst=1, on every clock edge the block SHALL force ch=0, Y0..Y7=0, shadow0..7=0, frame_vld=0, frame_cnt=0 and sync_err=0.
REQ-022 rst SHALL take priority over din_vld and sync_in.
REQ-023 A reset mid-frame SHALL discard the partial frame; the first word accepted after reset SHALL go to channel 0.

Configuration
REQ-024 When TDM_SYNC_EN is defined, a word accepted with sync_in=1 SHALL be written to channel 0, and ch SHALL become 1.
REQ-025 If that sync word arrives while ch is not 0, the partial frame SHALL be discarded with no output update, and sync_err SHALL pulse for one cycle.
REQ-026 sync_in SHALL be ignored when din_vld=0.
REQ-027 When TDM_SYNC_EN is not defined, the sync_in and sync_err ports SHALL be absent and channel alignment SHALL come from reset only.

Structure
REQ-028 The shared package demux_pkg SHALL hold the NCH constant, the channel index typedef chan_t (3 bits) and the frame-count width constant.
REQ-029 The channel counter, including wrap and sync-load logic, SHALL be one sub-module named tdm_chan_cnt; the datapath SHALL stay in the top module.

Verification
REQ-030 Reset, then words 0101, 1010, 1100, 1101, 0011, 1101, 1100, 1101 with din_vld=1 -> one cycle after the 8th word, Y0..Y7 equal those words in order, frame_vld=1 for one cycle, frame_cnt=1.
REQ-031 Same 8 words with din_vld=0 gaps of 1 to 3 cycles between them -> identical Y values; frame_vld pulses once, only after the 8th word.
REQ-032 Reset asserted after 3 accepted words of a frame -> Y all 0, ch=0; a following full frame 1100, 1101, 1101, 1111, 1100, 0000, 0011, 1100 appears intact.
REQ-033 Continuous din_vld for 2056 words -> frame_vld pulses every 8 cycles; frame_cnt wraps 255->0 and reads 1 at the end.
REQ-034 With TDM_SYNC_EN defined: 5 words, then sync_in=1 with din=0111 -> sync_err pulses, Y unchanged, ch=1; 7 more words complete a frame with Y0=0111.
REQ-035 Y0..Y7 SHALL be checked stable (unchanged) on every cycle where frame_vld=0.
